// File: rtl/regfile.sv
// 32 x DATA_W register file: two combinational read ports, one write port, committed-write counter.
// Optional same-cycle write-to-read forwarding is enabled by defining RF_BYPASS_EN.
module regfile #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              op_write,
  input  logic [31:0]       write_addr,
  input  logic [DATA_W-1:0] write_data,
  input  logic [4:0]        rs1_addr,
  input  logic [4:0]        rs2_addr,
  output logic [DATA_W-1:0] rs1_data,
  output logic [DATA_W-1:0] rs2_data,
  output logic [CNT_W-1:0]  wr_cnt,
  output logic              wr_ovf
);

  logic [4:0]        waddr;
  logic              wr_commit;
  logic [DATA_W-1:0] regs_q [1:31];
  logic [DATA_W-1:0] regs_d [1:31];
  logic [CNT_W-1:0]  wr_cnt_q;
  logic [CNT_W-1:0]  wr_cnt_d;
  logic              wr_ovf_q;
  logic              wr_ovf_d;
  logic [DATA_W-1:0] rd1;
  logic [DATA_W-1:0] rd2;
  logic              unused_addr_bits;

  // Only the low five index bits select a register; the rest never reach any logic.
  assign waddr            = write_addr[4:0];
  assign unused_addr_bits = ^write_addr[31:5];
  assign wr_commit        = op_write && (waddr != 5'd0);

  always_comb begin
    regs_d   = regs_q;
    wr_cnt_d = wr_cnt_q;
    wr_ovf_d = wr_ovf_q;
    if (wr_commit) begin
      for (int i = 1; i < 32; i++) begin
        if (waddr == 5'(i)) regs_d[i] = write_data;
      end
      wr_cnt_d = wr_cnt_q + CNT_W'(1);
      if (wr_cnt_q == {CNT_W{1'b1}}) wr_ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i < 32; i++) regs_q[i] <= '0;
      wr_cnt_q <= '0;
      wr_ovf_q <= 1'b0;
    end else begin
      regs_q   <= regs_d;
      wr_cnt_q <= wr_cnt_d;
      wr_ovf_q <= wr_ovf_d;
    end
  end

  always_comb begin
    rd1 = '0;
    rd2 = '0;
    for (int i = 1; i < 32; i++) begin
      if (rs1_addr == 5'(i)) rd1 = regs_q[i];
      if (rs2_addr == 5'(i)) rd2 = regs_q[i];
    end
`ifdef RF_BYPASS_EN
    // wr_commit already excludes x0, so forwarding can never make x0 non-zero.
    if (wr_commit && (waddr == rs1_addr)) rd1 = write_data;
    if (wr_commit && (waddr == rs2_addr)) rd2 = write_data;
`endif
  end

  // Reads are forced to zero while reset is held so forwarded data cannot leak out.
  assign rs1_data = rst_n ? rd1 : '0;
  assign rs2_data = rst_n ? rd2 : '0;
  assign wr_cnt   = wr_cnt_q;
  assign wr_ovf   = wr_ovf_q;

endmodule

// File: tb/tb_regfile.sv
// Directed bench for regfile (CNT_W=4): spec-level model checked every negedge plus literal checks.
module tb_regfile;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              op_write;
  logic [31:0]       write_addr;
  logic [DATA_W-1:0] write_data;
  logic [4:0]        rs1_addr;
  logic [4:0]        rs2_addr;
  logic [DATA_W-1:0] rs1_data;
  logic [DATA_W-1:0] rs2_data;
  logic [CNT_W-1:0]  wr_cnt;
  logic              wr_ovf;

  int errors = 0;
  int checks = 0;
  bit check_en = 0;

  regfile #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .op_write(op_write), .write_addr(write_addr),
    .write_data(write_data), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .wr_cnt(wr_cnt), .wr_ovf(wr_ovf)
  );

  always #5 clk = ~clk;

  // Behavioural model: plain array, integer counter mod 2^CNT_W, sticky overflow bit.
  logic [31:0] m_mem [32] = '{default: 32'h0};
  int          m_cnt = 0;
  bit          m_ovf = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) m_mem[i] = 32'h0;
      m_cnt = 0;
      m_ovf = 0;
    end else if (op_write && write_addr[4:0] != 5'd0) begin
      m_mem[write_addr[4:0]] = write_data;
      m_cnt = (m_cnt + 1) % (1 << CNT_W);
      if (m_cnt == 0) m_ovf = 1;
    end
  end

  function automatic logic [31:0] exp_read(input logic [4:0] a);
    if (!rst_n || a == 5'd0) return 32'h0;
`ifdef RF_BYPASS_EN
    if (op_write && write_addr[4:0] != 5'd0 && write_addr[4:0] == a) return write_data;
`endif
    return m_mem[a];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      check("model_rs1", rs1_data, exp_read(rs1_addr));
      check("model_rs2", rs2_data, exp_read(rs2_addr));
      check("model_cnt", 32'(wr_cnt), 32'(m_cnt));
      check("model_ovf", 32'(wr_ovf), 32'(m_ovf));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d);
    op_write   = 1'b1;
    write_addr = a;
    write_data = d;
    step();
    op_write = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; op_write = 1'b0; write_addr = '0; write_data = '0;
    rs1_addr = '0; rs2_addr = '0;

    // Held reset with a live write request: nothing commits, every read is zero.
    op_write = 1'b1; write_addr = 32'd5; write_data = 32'hFFFF_FFFF;
    for (int a = 0; a < 32; a++) begin
      step();
      rs1_addr = 5'(a);
      rs2_addr = 5'(31 - a);
      #1;
      check("rst_rs1", rs1_data, 32'h0);
      check("rst_rs2", rs2_data, 32'h0);
      check("rst_cnt", 32'(wr_cnt), 32'h0);
      check("rst_ovf", 32'(wr_ovf), 32'h0);
    end

    // Release reset between edges while the write is still requested.
    @(negedge clk); #2;
    rst_n = 1'b1;
    rs1_addr = 5'd5;
    #1;
    check("deassert_cnt", 32'(wr_cnt), 32'h0);
`ifdef RF_BYPASS_EN
    check("deassert_fwd", rs1_data, 32'hFFFF_FFFF);
`else
    check("deassert_x5", rs1_data, 32'h0);
`endif
    op_write = 1'b0;
    check_en = 1'b1;
    step();
    check("x5_uncommitted", rs1_data, 32'h0);

    do_write(32'd4, 32'hDEAD_BEEF);
    rs1_addr = 5'd4; rs2_addr = 5'd4; #1;
    check("basic_rs1", rs1_data, 32'hDEAD_BEEF);
    check("basic_rs2", rs2_data, 32'hDEAD_BEEF);
    check("basic_cnt", 32'(wr_cnt), 32'd1);

    do_write(32'd0, 32'h1234);
    write_addr = 32'd5; write_data = 32'h5555;
    step();
    rs1_addr = 5'd0; rs2_addr = 5'd5; #1;
    check("x0_read", rs1_data, 32'h0);
    check("dis_x5", rs2_data, 32'h0);
    check("x0_dis_cnt", 32'(wr_cnt), 32'd1);

    do_write(32'hFFFF_FFE3, 32'h77);
    rs1_addr = 5'd3; #1;
    check("upper_x3", rs1_data, 32'h77);
    do_write(32'hA5A5_A5C6, 32'h66);
    rs2_addr = 5'd6; #1;
    check("upper_x6", rs2_data, 32'h66);
    check("upper_cnt", 32'(wr_cnt), 32'd3);

    do_write(32'd7, 32'hA);
    op_write = 1'b1; write_addr = 32'd7; write_data = 32'hB; rs1_addr = 5'd7; rs2_addr = 5'd0;
    #1;
`ifdef RF_BYPASS_EN
    check("bypass_pre", rs1_data, 32'hB);
`else
    check("bypass_pre", rs1_data, 32'hA);
`endif
    check("bypass_x0", rs2_data, 32'h0);
    step();
    op_write = 1'b0; #1;
    check("bypass_post", rs1_data, 32'hB);
    check("bypass_cnt", 32'(wr_cnt), 32'd5);

    for (int i = 0; i < 10; i++) begin
      do_write(32'((i * 7) % 31 + 1), $urandom);
      rs2_addr = rs1_addr;
      rs1_addr = 5'((i * 7) % 31 + 1);
    end
    #1;
    check("pre_wrap_cnt", 32'(wr_cnt), 32'd15);
    check("pre_wrap_ovf", 32'(wr_ovf), 32'd0);
    do_write(32'd31, 32'h3131);
    rs1_addr = 5'd31; #1;
    check("wrap_cnt", 32'(wr_cnt), 32'd0);
    check("wrap_ovf", 32'(wr_ovf), 32'd1);
    check("wrap_x31", rs1_data, 32'h3131);
    step();
    check("ovf_sticky", 32'(wr_ovf), 32'd1);

    // Asynchronous reset pulse strictly between clock edges.
    @(negedge clk); #2;
    rs1_addr = 5'd4; rs2_addr = 5'd3; #1;
    check("pre_pulse_x4", rs1_data, 32'hDEAD_BEEF);
    rst_n = 1'b0; #1;
    check("pulse_rs1", rs1_data, 32'h0);
    check("pulse_rs2", rs2_data, 32'h0);
    check("pulse_cnt", 32'(wr_cnt), 32'h0);
    check("pulse_ovf", 32'(wr_ovf), 32'h0);
    rst_n = 1'b1;
    step();
    check("post_pulse_x4", rs1_data, 32'h0);
    check("post_pulse_x3", rs2_data, 32'h0);
    do_write(32'd4, 32'h4444);
    #1;
    check("post_pulse_wr", rs1_data, 32'h4444);
    check("post_pulse_cnt", 32'(wr_cnt), 32'd1);
    step();

    check_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
